// File: rtl/mux_nx1_sequencial.sv
// ============================================================================
//  Module      : mux_nx1_sequencial
//  Description : Parametrised N:1 registered multiplexer with valid/ready
//                handshakes. Manual mode forwards one selected lane per beat;
//                auto mode serialises all lanes of a beat, lane 0 first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nx1_sequencial #(
    parameter int DATA_WIDTH = 10,
    parameter int N_INPUTS   = 3,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] din,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           mode,
    input  logic [SEL_WIDTH-1:0]           sel,
    output logic [DATA_WIDTH-1:0]          mux_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SEL_WIDTH-1:0]           out_idx,
    output logic                           out_last
);

    localparam logic [SEL_WIDTH-1:0] c_LAST_IDX = SEL_WIDTH'(N_INPUTS - 1);
    localparam logic                 c_SINGLE   = (N_INPUTS == 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SERIAL = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_mux_out,   w_mux_out_nxt;
    logic                    r_out_valid, w_out_valid_nxt;
    logic [SEL_WIDTH-1:0]    r_out_idx,   w_out_idx_nxt;
    logic                    r_out_last,  w_out_last_nxt;
    logic [DATA_WIDTH-1:0]   r_hold      [N_INPUTS];
    logic [DATA_WIDTH-1:0]   w_hold_nxt  [N_INPUTS];
    logic [DATA_WIDTH-1:0]   w_lane      [N_INPUTS];

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_at_last;
    logic [SEL_WIDTH-1:0]    w_sel_sat;
    logic [SEL_WIDTH-1:0]    w_next_idx;
    logic [DATA_WIDTH-1:0]   w_man_word;
    logic [DATA_WIDTH-1:0]   w_hold_word;

    // Unpack the flat input bus into lanes
    for (genvar k = 0; k < N_INPUTS; k++) begin : g_lane
        assign w_lane[k] = din[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_at_last  = (r_out_idx == c_LAST_IDX);
    assign w_sel_sat  = (int'(sel) >= N_INPUTS) ? c_LAST_IDX : sel;
    assign w_next_idx = r_out_idx + 1'b1;
    assign w_accept   = in_valid & w_in_ready;

    // Input is ready when the output slot frees up and no serialisation is pending
    always_comb begin
        w_in_ready = 1'b0;
        if (rst_n) begin
            if (r_state == ST_IDLE) begin
                w_in_ready = !r_out_valid || out_ready;
            end else if (w_at_last) begin
                w_in_ready = out_ready;
            end
        end
    end

    // Lane pickers: manual-mode selection and next held lane during serialisation
    always_comb begin
        w_man_word  = '0;
        w_hold_word = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (w_sel_sat == SEL_WIDTH'(k)) begin
                w_man_word = w_lane[k];
            end
            if (w_next_idx == SEL_WIDTH'(k)) begin
                w_hold_word = r_hold[k];
            end
        end
    end

    // Next-state and output-register logic. An accept is only possible in IDLE
    // or on the last serial word, and is handled identically in both cases,
    // which gives gap-free back-to-back beats.
    always_comb begin
        w_state_nxt     = r_state;
        w_mux_out_nxt   = r_mux_out;
        w_out_valid_nxt = r_out_valid;
        w_out_idx_nxt   = r_out_idx;
        w_out_last_nxt  = r_out_last;
        w_hold_nxt      = r_hold;

        if (w_accept) begin
            w_out_valid_nxt = 1'b1;
            if (!mode) begin
                w_mux_out_nxt  = w_man_word;
                w_out_idx_nxt  = w_sel_sat;
                w_out_last_nxt = 1'b1;
                w_state_nxt    = ST_IDLE;
            end else begin
                w_hold_nxt     = w_lane;
                w_mux_out_nxt  = w_lane[0];
                w_out_idx_nxt  = '0;
                w_out_last_nxt = c_SINGLE;
                w_state_nxt    = c_SINGLE ? ST_IDLE : ST_SERIAL;
            end
        end else if ((r_state == ST_SERIAL) && !w_at_last) begin
            if (out_ready) begin
                w_mux_out_nxt  = w_hold_word;
                w_out_idx_nxt  = w_next_idx;
                w_out_last_nxt = (w_next_idx == c_LAST_IDX);
            end
        end else if (out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = ST_IDLE;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mux_out   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            for (int k = 0; k < N_INPUTS; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_mux_out   <= w_mux_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_out_last  <= w_out_last_nxt;
            r_hold      <= w_hold_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign mux_out   = r_mux_out;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule

`default_nettype wire
